// File: rtl/uart_program_loader.sv
// Boot-time program loader: pulls a big-endian length word plus that many words from the
// UART receive FIFO, writes them to instruction memory from address 0, then answers ACK or NAK.
module uart_program_loader #(
    parameter int         ADDR_WIDTH = 14,
    parameter logic [7:0] ACK_BYTE   = 8'hAA,
    parameter logic [7:0] NAK_BYTE   = 8'h55
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_ready_i,
    output logic                  rx_pop_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [31:0]           word_count_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_WRITE, S_TX, S_DONE, S_ERR
    } state_t;

    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [23:0]           shreg_q, shreg_d;
    logic [31:0]           wc_q, wc_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  ok_q, ok_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, tx_valid_q, busy_q, done_q, error_q;

    logic [31:0]           word;
    logic [ADDR_WIDTH:0]   idx_inc;

    assign word    = {shreg_q, rx_data_i};
    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        wc_d        = wc_q;
        tx_data_d   = tx_data_q;
        ok_d        = ok_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rx_pop_o    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d = S_LEN;
                    bcnt_d  = '0;
                    idx_d   = '0;
                end
            end
            S_LEN: begin
                rx_pop_o = rx_ready_i;
                if (rx_ready_i) begin
                    shreg_d = word[23:0];
                    bcnt_d  = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        wc_d = word;
                        if (word == 32'd0) begin
                            tx_data_d = ACK_BYTE;
                            ok_d      = 1'b1;
                            state_d   = S_TX;
                        end else if ({1'b0, word} > CAPACITY) begin
                            tx_data_d = NAK_BYTE;
                            ok_d      = 1'b0;
                            state_d   = S_TX;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                rx_pop_o = rx_ready_i;
                if (rx_ready_i) begin
                    shreg_d = word[23:0];
                    bcnt_d  = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        mem_addr_d  = idx_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = word;
                        state_d     = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                idx_d = idx_inc;
                if (32'(idx_inc) == wc_q) begin
                    tx_data_d = ACK_BYTE;
                    ok_d      = 1'b1;
                    state_d   = S_TX;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_TX: begin
                if (tx_ready_i) state_d = ok_q ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status strobes are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            bcnt_q      <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            wc_q        <= '0;
            tx_data_q   <= '0;
            ok_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            wc_q        <= wc_d;
            tx_data_q   <= tx_data_d;
            ok_q        <= ok_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= (state_d == S_WRITE);
            tx_valid_q  <= (state_d == S_TX);
            busy_q      <= (state_d == S_LEN) || (state_d == S_DATA) ||
                           (state_d == S_WRITE) || (state_d == S_TX);
            done_q      <= (state_d == S_DONE);
            error_q     <= (state_d == S_ERR);
        end
    end

    assign tx_data_o    = tx_data_q;
    assign tx_valid_o   = tx_valid_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign word_count_o = wc_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: a byte-FIFO model feeds the loader while
// expected memory writes and transmit bytes are queued and checked as they appear.
module tb_uart_program_loader;
    localparam int AW = 4;

    logic          clk_i = 1'b0;
    logic          reset_i, start_i, rx_ready_i, tx_ready_i;
    logic [7:0]    rx_data_i;
    logic          rx_pop_o, tx_valid_o, mem_we_o, busy_o, done_o, error_o;
    logic [7:0]    tx_data_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o, word_count_o;

    always #5 clk_i = ~clk_i;

    uart_program_loader #(.ADDR_WIDTH(AW), .ACK_BYTE(8'hAA), .NAK_BYTE(8'h55)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
        .rx_data_i(rx_data_i), .rx_ready_i(rx_ready_i), .rx_pop_o(rx_pop_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .word_count_o(word_count_o)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];
    logic [7:0] fifo[$];
    int         tests = 0;
    int         failed = 0;
    int         pops = 0;
    logic       gate = 1'b1;
    logic       bp_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic update_rx();
        rx_ready_i = gate && (fifo.size() != 0);
        rx_data_i  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    // One clock: sample at the falling edge, advance the FIFO model just after the rising edge.
    task automatic step();
        logic fire;
        wr_t  e;
        @(negedge clk_i);
        fire = rx_pop_o && rx_ready_i;
        if (mem_we_o) begin
            chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
                e = exp_wr.pop_front();
                chk("wr_addr", 32'(mem_addr_o), 32'(e.addr));
                chk("wr_data", mem_wdata_o, e.data);
            end
        end
        if (tx_valid_o && tx_ready_i) begin
            chk("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
            if (exp_tx.size() != 0) chk("tx_byte", 32'(tx_data_o), 32'(exp_tx.pop_front()));
        end
        @(posedge clk_i);
        #1;
        if (fire) begin
            void'(fifo.pop_front());
            pops++;
        end
        gate = bp_mode ? ~gate : 1'b1;
        update_rx();
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo.push_back(w[31:24]);
        fifo.push_back(w[23:16]);
        fifo.push_back(w[15:8]);
        fifo.push_back(w[7:0]);
        update_rx();
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [31:0] w);
        wr_t e;
        e.addr = a;
        e.data = w;
        exp_wr.push_back(e);
        push_word(w);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        for (int i = 0; i < budget && !(done_o || error_o); i++) step();
        chk(tag, 32'(done_o || error_o), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_flags"}, 32'({busy_o, done_o, error_o, tx_valid_o, mem_we_o, rx_pop_o}), 32'd0);
        chk({tag, "_wc"}, word_count_o, 32'd0);
        chk({tag, "_txd"}, 32'(tx_data_o), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr_o), 32'd0);
        chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
    endtask

    initial begin
        reset_i    = 1'b0;
        start_i    = 1'b0;
        tx_ready_i = 1'b1;
        update_rx();
        step();
        step();
        check_reset_state("rst");
        reset_i = 1'b1;
        step();

        // normal two-word load
        pops = 0;
        push_word(32'd2);
        push_exp(4'd0, 32'hDEADBEEF);
        push_exp(4'd1, 32'h01234567);
        exp_tx.push_back(8'hAA);
        pulse_start();
        wait_end("t1_end", 100);
        chk("t1_done", 32'({done_o, error_o, busy_o}), 32'b100);
        chk("t1_wc", word_count_o, 32'd2);
        chk("t1_txd", 32'(tx_data_o), 32'hAA);
        chk("t1_pops", 32'(pops), 32'd12);
        chk("t1_wr_left", 32'(exp_wr.size()), 32'd0);
        chk("t1_tx_left", 32'(exp_tx.size()), 32'd0);

        // start in DONE reloads and overwrites address 0
        pops = 0;
        push_word(32'd1);
        push_exp(4'd0, 32'h11223344);
        exp_tx.push_back(8'hAA);
        pulse_start();
        chk("t2_done_clr", 32'({done_o, busy_o}), 32'b01);
        wait_end("t2_end", 100);
        chk("t2_done", 32'(done_o), 32'd1);
        chk("t2_wr_left", 32'(exp_wr.size()), 32'd0);

        // zero count
        pops = 0;
        push_word(32'd0);
        exp_tx.push_back(8'hAA);
        pulse_start();
        wait_end("t3_end", 50);
        chk("t3_flags", 32'({done_o, error_o}), 32'b10);
        chk("t3_wc", word_count_o, 32'd0);
        chk("t3_tx_left", 32'(exp_tx.size()), 32'd0);

        // one past capacity: NAK, trailing byte stays queued
        pops = 0;
        push_word(32'd17);
        fifo.push_back(8'h99);
        update_rx();
        exp_tx.push_back(8'h55);
        pulse_start();
        wait_end("t4_end", 50);
        step();
        step();
        step();
        chk("t4_flags", 32'({done_o, error_o}), 32'b01);
        chk("t4_wc", word_count_o, 32'd17);
        chk("t4_pops", 32'(pops), 32'd4);
        chk("t4_fifo_left", 32'(fifo.size()), 32'd1);
        chk("t4_tx_left", 32'(exp_tx.size()), 32'd0);
        fifo.delete();
        update_rx();

        // exactly capacity
        pops = 0;
        push_word(32'd16);
        for (int i = 0; i < 16; i++) push_exp(AW'(i), 32'hC0DE0000 | 32'(i));
        exp_tx.push_back(8'hAA);
        pulse_start();
        wait_end("t5_end", 300);
        chk("t5_flags", 32'({done_o, error_o}), 32'b10);
        chk("t5_last_addr", 32'(mem_addr_o), 32'd15);
        chk("t5_pops", 32'(pops), 32'd68);
        chk("t5_wr_left", 32'(exp_wr.size()), 32'd0);
        chk("t5_tx_left", 32'(exp_tx.size()), 32'd0);

        // backpressure on both sides
        pops = 0;
        bp_mode    = 1'b1;
        tx_ready_i = 1'b0;
        push_word(32'd2);
        push_exp(4'd0, 32'h89ABCDEF);
        push_exp(4'd1, 32'h76543210);
        exp_tx.push_back(8'hAA);
        pulse_start();
        for (int i = 0; i < 100 && !tx_valid_o; i++) step();
        chk("t6_txv_seen", 32'(tx_valid_o), 32'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t6_txv_hold", 32'({tx_valid_o, done_o}), 32'b10);
            chk("t6_txd_hold", 32'(tx_data_o), 32'hAA);
        end
        tx_ready_i = 1'b1;
        wait_end("t6_end", 20);
        bp_mode = 1'b0;
        chk("t6_done", 32'(done_o), 32'd1);
        chk("t6_wr_left", 32'(exp_wr.size()), 32'd0);
        chk("t6_tx_left", 32'(exp_tx.size()), 32'd0);

        // start pulse during DATA is ignored
        pops = 0;
        push_word(32'd2);
        push_exp(4'd0, 32'hA5A5F00F);
        push_exp(4'd1, 32'h3C3C1234);
        exp_tx.push_back(8'hAA);
        pulse_start();
        for (int i = 0; i < 6; i++) step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_end("t7_end", 100);
        chk("t7_done", 32'(done_o), 32'd1);
        chk("t7_pops", 32'(pops), 32'd12);
        chk("t7_wr_left", 32'(exp_wr.size()), 32'd0);

        // reset mid-load, then a fresh one-word load
        pops = 0;
        push_word(32'd2);
        push_word(32'h12345678);
        push_word(32'h9ABCDEF0);
        pulse_start();
        for (int i = 0; i < 50 && pops < 6; i++) step();
        chk("t8_pops_before", 32'(pops), 32'd6);
        reset_i = 1'b0;
        #1;
        check_reset_state("t8_rst");
        fifo.delete();
        update_rx();
        step();
        reset_i = 1'b1;
        step();
        pops = 0;
        push_word(32'd1);
        push_exp(4'd0, 32'hCAFEBABE);
        exp_tx.push_back(8'hAA);
        pulse_start();
        wait_end("t8_end", 100);
        chk("t8_done", 32'({done_o, error_o}), 32'b10);
        chk("t8_wc", word_count_o, 32'd1);
        chk("t8_pops", 32'(pops), 32'd8);
        chk("t8_wr_left", 32'(exp_wr.size()), 32'd0);
        chk("t8_tx_left", 32'(exp_tx.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Boot-time program loader that sits directly downstream of the UART block's receive FIFO and upstream of its transmit path. On `start` it pops a big-endian 32-bit word count followed by that many big-endian 32-bit words, writes each word to instruction memory at consecutive word addresses from 0, then sends a one-byte ACK or NAK back through the UART transmit side. The core is held in reset by the system until `done` rises.

## Interface
- `ADDR_WIDTH`, 14: word-address width of instruction memory; capacity is 2^ADDR_WIDTH words.
- `ACK_BYTE`, 8'hAA: byte transmitted after a successful load.
- `NAK_BYTE`, 8'h55: byte transmitted when the word count exceeds capacity.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- `start`  in  1  level; sampled only in IDLE, DONE and ERR.
- `rx_data`  in  8  head byte of the UART receive FIFO; valid while `rx_ready`=1.
- `rx_ready`  in  1  receive FIFO non-empty.
- `rx_pop`  out  1  byte consumed in any cycle where `rx_pop`=1 and `rx_ready`=1.
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  transmit request.
- `tx_ready`  in  1  byte taken when `tx_valid`=1 and `tx_ready`=1.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_addr`  out  ADDR_WIDTH  word address.
- `mem_wdata`  out  32  word to write.
- `busy`  out  1  high in LEN, DATA, WRITE and TX.
- `done`  out  1  high in DONE.
- `error`  out  1  high in ERR.
- `word_count`  out  32  last received length header.

## Operation
- Reset (`reset`=0): state IDLE, and every output is 0. This includes `word_count`, `tx_data`, `mem_addr` and `mem_wdata`. A partially assembled word and byte counter are discarded.
- States:
  - IDLE, LEN, DATA, WRITE, TX, DONE, ERR.
  - `rx_pop` is combinational and equals `rx_ready` in LEN and DATA, 0 elsewhere.
- IDLE/DONE/ERR with `start`=1:
  - Go to LEN.
  - Clear the byte counter (2 bits) and the word index (ADDR_WIDTH+1 bits).
  - Clear `done` and `error`.
- LEN:
  - Each accepted byte updates `shreg <= {shreg[23:0], rx_data}`.
  - On the 4th byte, `word_count` takes the assembled value and the next state is decided as follows.
  - Count 0: load `tx_data`=ACK_BYTE and go to TX with the success flag set.
  - Count greater than 2^ADDR_WIDTH (compared at 33 bits): load NAK_BYTE and go to TX with the success flag clear.
  - Otherwise go to DATA.
- DATA: shift accepted bytes the same way. On the 4th byte go to WRITE.
- WRITE (exactly one cycle):
  - `mem_we`=1, `mem_addr`=word index[ADDR_WIDTH-1:0], `mem_wdata`=assembled word.
  - Increment the word index.
  - If the new index equals `word_count`, load ACK_BYTE and go to TX; otherwise return to DATA.
  - `rx_pop`=0 in this state.
- TX:
  - `tx_valid`=1 with `tx_data` held stable until `tx_ready`=1.
  - Then go to DONE (success) or ERR (NAK).
- DONE/ERR:
  - Levels hold until `start` or reset.
  - Bytes arriving in these states are left in the FIFO.
- `start` in LEN, DATA, WRITE or TX is ignored.
- Count exactly 2^ADDR_WIDTH is legal. The last write targets `mem_addr` = all ones.

## Timing
- All outputs except `rx_pop` are registered.
- `mem_we` rises in the cycle after the cycle accepting a word's 4th byte.
- Maximum throughput is one byte per cycle plus one WRITE bubble per word, so N words take at least 4+5N cycles from the first pop to the final WRITE.
- `tx_valid` rises in the cycle after the final WRITE. For count 0 or overflow, it rises in the cycle after the 4th length byte.
- `done` or `error` rises in the cycle after the `tx_valid`&&`tx_ready` handshake.
- `busy` falls in the same cycle that `done` or `error` rises.
- Gaps in `rx_ready` stall assembly with no state loss.
- Reset asserted mid-operation takes effect asynchronously. Release resumes in IDLE.

## Test plan
- Normal load: start, then bytes 00 00 00 02 DE AD BE EF 01 23 45 67.
  - Required: writes (0, DEADBEEF) then (1, 01234567), each `mem_we` exactly one cycle.
  - Then `tx_data`=AA, `done`=1, `word_count`=2, exactly 12 pops.
- Zero count: start, then 00 00 00 00.
  - Required: no `mem_we`, AA transmitted, `done`=1, `error`=0.
- Capacity boundary with ADDR_WIDTH=4:
  - Count 17 gives tx 55, `error`=1, no writes, and a following byte is not popped.
  - Count 16 gives 16 writes with last address 15, then AA.
- Backpressure: `rx_ready` toggles every other cycle and `tx_ready` is held 0 for 5 cycles.
  - Required: words assemble correctly, and `tx_valid`=1 and `tx_data`=AA stay stable across all 5 stall cycles.
- Reset mid-load: `reset`=0 after 6 bytes of a count-2 stream.
  - Required: all outputs 0 immediately.
  - After release, start plus a fresh count-1 stream (00 00 00 01 CA FE BA BE) writes (0, CAFEBABE) only.
- Start handling:
  - A `start` pulse while in DATA changes nothing.
  - `start` in DONE clears `done` next cycle and reloads, overwriting address 0.
